// File: rtl/ddr_rw_app_if.sv
// ddr_rw_app_if: memory-controller application-port bundle.
//   Command channel : app_cmd, app_addr, app_en  -> / <- app_rdy
//   Write-data path : app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end -> / <- app_wdf_rdy
//   Read return     : <- app_rd_data, app_rd_data_valid
// master = user-side engine (drives commands/write data), slave = controller.
interface ddr_rw_app_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic [2:0]          app_cmd;
    logic [ADDR_W-1:0]   app_addr;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;

    modport master (
        output app_cmd, app_addr, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_cmd, app_addr, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_rw_app.sv
// ddr_rw_app: issues bl back-to-back burst commands to a DDR controller app
// port in write or read mode. Command and write-data paths are handshaked
// independently; read returns are forwarded with one cycle of latency and
// the number of outstanding read commands is capped at MAX_OUTST.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, wr_rd, bl, addr start pulse (IDLE only), direction, burst count, start address
//   dat_i, dat_req      show-ahead write data, consumed when dat_req=1
//   rd_dat, rd_vld      registered read data to the user
//   done, busy, err     completion pulse, in-progress flag, abort pulse
//   app                 controller application port (ddr_rw_app_if.master)
// Optional: define TIMEOUT_EN to add a stall watchdog (TIMEOUT_CYC cycles)
// that aborts with an err pulse; otherwise err is tied 0.
module ddr_rw_app #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter int BURST_L     = 8,
    parameter int BL_W        = 8,
    parameter int MAX_OUTST   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_rd,
    input  logic [BL_W-1:0]   bl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dat_i,
    output logic              dat_req,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_vld,
    output logic              done,
    output logic              busy,
    output logic              err,
    ddr_rw_app_if.master      app
);

    if (MAX_OUTST < 1 || MAX_OUTST > (1 << BL_W) - 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("ddr_rw_app: MAX_OUTST or TIMEOUT_CYC out of range");
    end

    localparam logic [BL_W-1:0]   MAX_O = BL_W'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BURST_L);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WR   = 3'b010,
        RD   = 3'b100
    } state_t;

    state_t              state_q;
    logic [BL_W-1:0]     bl_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BL_W-1:0]     cmd_cnt_q, dat_cnt_q, ret_cnt_q;
    logic [BL_W-1:0]     cmd_cnt_d, dat_cnt_d, ret_cnt_d;
    logic [2:0]          app_cmd_q;
    logic [DATA_W-1:0]   rd_dat_q;
    logic                rd_vld_q, done_q, busy_q, err_q;

    logic                is_wr, is_rd, cmd_room;
    logic [BL_W-1:0]     outst;
    logic                app_en_w, wren_w;
    logic                cmd_hs, dat_hs, ret_hs;
    logic                wr_fin, rd_fin;
    logic                wd_fire;

    always_comb begin
        is_wr     = (state_q == WR);
        is_rd     = (state_q == RD);
        cmd_room  = (cmd_cnt_q < bl_q);
        // cmd_cnt never trails ret_cnt, so the modular difference is exact
        outst     = cmd_cnt_q - ret_cnt_q;
        app_en_w  = (is_wr & cmd_room) | (is_rd & cmd_room & (outst < MAX_O));
        wren_w    = is_wr & (dat_cnt_q < bl_q);
        cmd_hs    = app_en_w & app.app_rdy;
        dat_hs    = wren_w & app.app_wdf_rdy;
        ret_hs    = is_rd & app.app_rd_data_valid;
        cmd_cnt_d = cmd_cnt_q + BL_W'(cmd_hs);
        dat_cnt_d = dat_cnt_q + BL_W'(dat_hs);
        ret_cnt_d = ret_cnt_q + BL_W'(ret_hs);
        // look at post-handshake counts so a same-cycle final cmd+data finishes
        wr_fin    = is_wr & (cmd_cnt_d == bl_q) & (dat_cnt_d == bl_q);
        rd_fin    = is_rd & (ret_cnt_d == bl_q);
    end

`ifdef TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;

    always_comb begin
        if (state_q == IDLE || cmd_hs || dat_hs || ret_hs) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
        wd_fire = (wdog_d == WD_W'(TIMEOUT_CYC));
    end

    always_ff @(posedge clk) begin
        if (rst || wd_fire) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bl_q      <= '0;
            addr_q    <= '0;
            cmd_cnt_q <= '0;
            dat_cnt_q <= '0;
            ret_cnt_q <= '0;
            app_cmd_q <= '0;
            rd_dat_q  <= '0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= ret_hs;
            if (ret_hs) begin
                rd_dat_q <= app.app_rd_data;
            end
            // busy covers the done/err cycle, then drops (unless restarted)
            if (done_q || err_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (en) begin
                        bl_q      <= (bl == '0) ? BL_W'(1) : bl;
                        addr_q    <= addr;
                        app_cmd_q <= wr_rd ? 3'b000 : 3'b001;
                        cmd_cnt_q <= '0;
                        dat_cnt_q <= '0;
                        ret_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= wr_rd ? WR : RD;
                    end
                end
                WR: begin
                    cmd_cnt_q <= cmd_cnt_d;
                    dat_cnt_q <= dat_cnt_d;
                    if (wr_fin) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (wd_fire) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end
                end
                RD: begin
                    cmd_cnt_q <= cmd_cnt_d;
                    ret_cnt_q <= ret_cnt_d;
                    if (rd_fin) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (wd_fire) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign app.app_cmd      = app_cmd_q;
    assign app.app_addr     = addr_q + ADDR_W'(cmd_cnt_q) * STEP;
    assign app.app_en       = app_en_w;
    assign app.app_wdf_data = dat_i;
    assign app.app_wdf_mask = '0;
    assign app.app_wdf_wren = wren_w;
    assign app.app_wdf_end  = wren_w;

    assign dat_req = dat_hs;
    assign rd_dat  = rd_dat_q;
    assign rd_vld  = rd_vld_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ddr_rw_app.sv
// tb_ddr_rw_app: randomized self-checking bench for ddr_rw_app. The reference
// model tracks each transaction as lists of expected addresses and data words
// plus issued/returned counts and predicts done/busy timing from them.
module tb_ddr_rw_app;
    localparam int AW = 28, DW = 128, BLW = 8, MAXO = 4, TCYC = 16, STEP = 8;

    logic          clk = 1'b0;
    logic          rst, en, wr_rd;
    logic [BLW-1:0] bl;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat_i;
    logic          dat_req, rd_vld, done, busy, err;
    logic [DW-1:0] rd_dat;
    int            total = 0;
    int            bad = 0;

    ddr_rw_app_if #(.ADDR_W(AW), .DATA_W(DW)) app_bus ();

    ddr_rw_app #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_L(STEP), .BL_W(BLW),
        .MAX_OUTST(MAXO), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_rd(wr_rd), .bl(bl), .addr(addr),
        .dat_i(dat_i), .dat_req(dat_req), .rd_dat(rd_dat), .rd_vld(rd_vld),
        .done(done), .busy(busy), .err(err), .app(app_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int i);
        logic [AW-1:0] off;
        off = AW'(i * STEP);
        return a + off;
    endfunction

    task automatic idle_inputs();
        en = 1'b0;
        app_bus.app_rdy = 1'b0;
        app_bus.app_wdf_rdy = 1'b0;
        app_bus.app_rd_data_valid = 1'b0;
        app_bus.app_rd_data = '0;
        dat_i = '0;
    endtask

    task automatic start_txn(input logic w, input logic [BLW-1:0] b, input logic [AW-1:0] a);
        @(negedge clk);
        en = 1'b1; wr_rd = w; bl = b; addr = a;
        @(negedge clk);
        en = 1'b0; bl = 8'($urandom()); addr = 28'($urandom());
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [BLW-1:0] b, input int rdy_low,
                             input int rdy_pct, input int wdf_pct, output int fin_o);
        int n, cmds, dats, fin, cyc;
        bit ended;
        logic [DW-1:0] words[$];
        logic exp_b, exp_d;
        n = (b == 0) ? 1 : int'(b);
        for (int i = 0; i < n; i++) words.push_back(rnd128());
        cmds = 0; dats = 0; fin = 0; ended = 0;
        start_txn(1'b1, b, a);
        for (cyc = 1; cyc <= 400; cyc++) begin
            app_bus.app_rdy = (cyc > rdy_low) && ($urandom_range(99) < rdy_pct);
            app_bus.app_wdf_rdy = ($urandom_range(99) < wdf_pct);
            app_bus.app_rd_data_valid = 1'($urandom_range(1));
            app_bus.app_rd_data = rnd128();
            dat_i = (dats < n) ? words[dats] : rnd128();
            if (fin == 0) begin
                en = 1'($urandom_range(1)); wr_rd = 1'($urandom_range(1));
                bl = 8'($urandom()); addr = 28'($urandom());
            end else begin
                en = 1'b0;
            end
            #1;
            exp_b = (fin == 0) || (cyc <= fin + 1);
            exp_d = (fin != 0) && (cyc == fin + 1);
            total++; if (busy !== exp_b) begin bad++; $display("FAIL wr_busy cyc=%0d got=%b want=%b", cyc, busy, exp_b); end
            total++; if (done !== exp_d) begin bad++; $display("FAIL wr_done cyc=%0d got=%b want=%b", cyc, done, exp_d); end
            total++; if (rd_vld !== 1'b0) begin bad++; $display("FAIL wr_rdvld_drop cyc=%0d got=%b want=0", cyc, rd_vld); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err cyc=%0d got=%b want=0", cyc, err); end
            if (fin == 0) begin
                total++; if (app_bus.app_en !== (cmds < n)) begin bad++; $display("FAIL wr_app_en cyc=%0d got=%b want=%b", cyc, app_bus.app_en, cmds < n); end
                total++; if (app_bus.app_wdf_wren !== (dats < n)) begin bad++; $display("FAIL wr_wren cyc=%0d got=%b want=%b", cyc, app_bus.app_wdf_wren, dats < n); end
                total++; if (app_bus.app_wdf_end !== (dats < n)) begin bad++; $display("FAIL wr_end cyc=%0d got=%b want=%b", cyc, app_bus.app_wdf_end, dats < n); end
                total++; if (dat_req !== ((dats < n) && app_bus.app_wdf_rdy)) begin bad++; $display("FAIL wr_dat_req cyc=%0d got=%b want=%b", cyc, dat_req, (dats < n) && app_bus.app_wdf_rdy); end
                if (app_bus.app_en && app_bus.app_rdy) begin
                    total++; if (app_bus.app_addr !== exp_addr(a, cmds)) begin bad++; $display("FAIL wr_addr k=%0d got=%h want=%h", cmds, app_bus.app_addr, exp_addr(a, cmds)); end
                    total++; if (app_bus.app_cmd !== 3'b000) begin bad++; $display("FAIL wr_cmd got=%b want=000", app_bus.app_cmd); end
                    cmds++;
                end
                if (dat_req && dats < n) begin
                    total++; if (app_bus.app_wdf_data !== words[dats]) begin bad++; $display("FAIL wr_data k=%0d got=%h want=%h", dats, app_bus.app_wdf_data, words[dats]); end
                    total++; if (app_bus.app_wdf_mask !== '0) begin bad++; $display("FAIL wr_mask got=%h want=0", app_bus.app_wdf_mask); end
                    dats++;
                end
                if (cmds == n && dats == n) fin = cyc;
            end else begin
                total++; if ({app_bus.app_en, app_bus.app_wdf_wren} !== 2'b00) begin bad++; $display("FAIL wr_idle_en cyc=%0d got=%b want=00", cyc, {app_bus.app_en, app_bus.app_wdf_wren}); end
            end
            if (fin != 0 && cyc == fin + 2) begin ended = 1; break; end
            @(negedge clk);
        end
        total++; if (!ended) begin bad++; $display("FAIL wr_timeout got=cmds %0d dats %0d want=%0d", cmds, dats, n); end
        idle_inputs();
        fin_o = fin;
    endtask

    task automatic run_read(input logic [AW-1:0] a, input logic [BLW-1:0] b, input int lat_lo,
                            input int lat_hi, input int rdy_pct, output int fin_o, output int max_o);
        int n, issued, returned, fin, cyc, last_due, lat;
        bit ended;
        int due_q[$];
        logic [DW-1:0] dat_q[$];
        logic exp_vld, in_rd, drv_vld, exp_b, exp_d, exp_en;
        logic [DW-1:0] exp_dat, drv_dat;
        n = (b == 0) ? 1 : int'(b);
        issued = 0; returned = 0; fin = 0; last_due = 0; max_o = 0; ended = 0;
        exp_vld = 1'b0; exp_dat = '0;
        start_txn(1'b0, b, a);
        for (cyc = 1; cyc <= 600; cyc++) begin
            in_rd = (fin == 0);
            app_bus.app_rdy = ($urandom_range(99) < rdy_pct);
            app_bus.app_wdf_rdy = 1'($urandom_range(1));
            drv_dat = rnd128();
            if (in_rd && due_q.size() > 0 && due_q[0] <= cyc) begin
                drv_vld = 1'b1; drv_dat = dat_q[0];
            end else if (!in_rd) begin
                drv_vld = 1'($urandom_range(1));
            end else begin
                drv_vld = 1'b0;
            end
            app_bus.app_rd_data_valid = drv_vld;
            app_bus.app_rd_data = drv_dat;
            dat_i = rnd128();
            en = in_rd ? 1'($urandom_range(1)) : 1'b0;
            wr_rd = 1'($urandom_range(1)); bl = 8'($urandom()); addr = 28'($urandom());
            #1;
            exp_b = (fin == 0) || (cyc <= fin + 1);
            exp_d = (fin != 0) && (cyc == fin + 1);
            total++; if (rd_vld !== exp_vld) begin bad++; $display("FAIL rd_vld cyc=%0d got=%b want=%b", cyc, rd_vld, exp_vld); end
            if (exp_vld) begin
                total++; if (rd_dat !== exp_dat) begin bad++; $display("FAIL rd_dat cyc=%0d got=%h want=%h", cyc, rd_dat, exp_dat); end
            end
            total++; if (busy !== exp_b) begin bad++; $display("FAIL rd_busy cyc=%0d got=%b want=%b", cyc, busy, exp_b); end
            total++; if (done !== exp_d) begin bad++; $display("FAIL rd_done cyc=%0d got=%b want=%b", cyc, done, exp_d); end
            total++; if ({err, app_bus.app_wdf_wren, dat_req} !== 3'b000) begin bad++; $display("FAIL rd_quiet cyc=%0d got=%b want=000", cyc, {err, app_bus.app_wdf_wren, dat_req}); end
            if (in_rd) begin
                exp_en = (issued < n) && (issued - returned < MAXO);
                total++; if (app_bus.app_en !== exp_en) begin bad++; $display("FAIL rd_app_en cyc=%0d got=%b want=%b", cyc, app_bus.app_en, exp_en); end
                if (app_bus.app_en && app_bus.app_rdy) begin
                    total++; if (app_bus.app_addr !== exp_addr(a, issued)) begin bad++; $display("FAIL rd_addr k=%0d got=%h want=%h", issued, app_bus.app_addr, exp_addr(a, issued)); end
                    total++; if (app_bus.app_cmd !== 3'b001) begin bad++; $display("FAIL rd_cmd got=%b want=001", app_bus.app_cmd); end
                    issued++;
                    lat = int'($urandom_range(lat_hi, lat_lo));
                    last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    due_q.push_back(last_due);
                    dat_q.push_back(rnd128());
                    if (issued - returned > max_o) max_o = issued - returned;
                end
                if (drv_vld) begin
                    void'(due_q.pop_front());
                    void'(dat_q.pop_front());
                    returned++;
                    if (returned == n) fin = cyc;
                end
            end else begin
                total++; if (app_bus.app_en !== 1'b0) begin bad++; $display("FAIL rd_idle_en cyc=%0d got=%b want=0", cyc, app_bus.app_en); end
            end
            exp_vld = in_rd && drv_vld;
            exp_dat = drv_dat;
            if (fin != 0 && cyc == fin + 2) begin ended = 1; break; end
            @(negedge clk);
        end
        total++; if (!ended) begin bad++; $display("FAIL rd_timeout got=returned %0d want=%0d", returned, n); end
        idle_inputs();
        fin_o = fin;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); en = 1'b1; wr_rd = 1'b1; bl = 8'd4; addr = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if ({done, busy, err, rd_vld, app_bus.app_en, app_bus.app_wdf_wren, app_bus.app_wdf_end, dat_req} !== 8'h00) begin
            bad++; $display("FAIL reset_flags got=%b want=00000000", {done, busy, err, rd_vld, app_bus.app_en, app_bus.app_wdf_wren, app_bus.app_wdf_end, dat_req}); end
        total++; if (rd_dat !== '0) begin bad++; $display("FAIL reset_rd_dat got=%h want=0", rd_dat); end
        total++; if (app_bus.app_cmd !== 3'b000) begin bad++; $display("FAIL reset_app_cmd got=%b want=000", app_bus.app_cmd); end
        total++; if (app_bus.app_wdf_mask !== '0) begin bad++; $display("FAIL reset_mask got=%h want=0", app_bus.app_wdf_mask); end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_write();
        int fin;
        run_write(28'h100, 8'd4, 0, 100, 100, fin);
        total++; if (fin !== 4) begin bad++; $display("FAIL basic_wr_fin got=%0d want=4", fin); end
    endtask

    task automatic test_write_cmd_lag();
        int fin;
        run_write(28'($urandom()), 8'd3, 5, 100, 100, fin);
        total++; if (fin !== 8) begin bad++; $display("FAIL cmd_lag_fin got=%0d want=8", fin); end
    endtask

    task automatic test_read_outstanding();
        int fin, mo;
        run_read(28'h2000, 8'd20, 10, 10, 100, fin, mo);
        total++; if (mo !== MAXO) begin bad++; $display("FAIL rd_max_outst got=%0d want=%0d", mo, MAXO); end
    endtask

    task automatic test_bl_zero_wrap();
        int fin;
        run_write(28'($urandom()) & ~28'h7, 8'd0, 0, 100, 100, fin);
        total++; if (fin !== 1) begin bad++; $display("FAIL bl0_fin got=%0d want=1", fin); end
        run_write(28'hFFFFFF8, 8'd2, 0, 100, 100, fin);
        total++; if (fin !== 2) begin bad++; $display("FAIL wrap_fin got=%0d want=2", fin); end
    endtask

    task automatic test_reset_mid_read();
        int issued, returned, fin;
        int due_q[$];
        issued = 0; returned = 0;
        start_txn(1'b0, 8'd8, 28'h4000);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            app_bus.app_rdy = 1'b1;
            app_bus.app_rd_data_valid = (due_q.size() > 0 && due_q[0] <= cyc);
            app_bus.app_rd_data = rnd128();
            #1;
            if (app_bus.app_en && app_bus.app_rdy) begin issued++; due_q.push_back(cyc + 3 + issued); end
            if (app_bus.app_rd_data_valid) begin void'(due_q.pop_front()); returned++; end
            if (returned == 2) break;
            @(negedge clk);
        end
        total++; if (returned !== 2) begin bad++; $display("FAIL rst_mid_progress got=%0d want=2", returned); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if ({busy, done, err, rd_vld, app_bus.app_en} !== 5'b00000) begin
                bad++; $display("FAIL rst_mid_idle k=%0d got=%b want=00000", k, {busy, done, err, rd_vld, app_bus.app_en}); end
            @(negedge clk);
        end
        run_write(28'($urandom()), 8'd3, 0, 80, 80, fin);
    endtask

    task automatic test_random();
        int fin, mo, rp, wp;
        logic [AW-1:0] a;
        logic [BLW-1:0] b;
        for (int t = 0; t < 16; t++) begin
            a = 28'($urandom());
            b = 8'($urandom_range(12));
            rp = int'($urandom_range(100, 50));
            wp = int'($urandom_range(100, 50));
            if ($urandom_range(1) == 1) begin
                run_write(a, b, int'($urandom_range(3)), rp, wp, fin);
            end else begin
                run_read(a, b, 1, int'($urandom_range(8, 1)), rp, fin, mo);
                total++; if (mo > MAXO) begin bad++; $display("FAIL rand_outst got=%0d want<=%0d", mo, MAXO); end
            end
        end
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        start_txn(1'b1, 8'd2, 28'h800);
        // err rises on the 16th edge after the accepting edge
        for (int cyc = 1; cyc <= 20; cyc++) begin
            #1;
            total++; if (err !== (cyc == TCYC + 1)) begin bad++; $display("FAIL to_err cyc=%0d got=%b want=%b", cyc, err, cyc == TCYC + 1); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL to_done cyc=%0d got=%b want=0", cyc, done); end
            total++; if (busy !== (cyc <= TCYC + 1)) begin bad++; $display("FAIL to_busy cyc=%0d got=%b want=%b", cyc, busy, cyc <= TCYC + 1); end
            total++; if (app_bus.app_en !== (cyc <= TCYC)) begin bad++; $display("FAIL to_app_en cyc=%0d got=%b want=%b", cyc, app_bus.app_en, cyc <= TCYC); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_write();
        test_write_cmd_lag();
        test_read_outstanding();
        test_bl_zero_wrap();
        test_reset_mid_read();
        test_random();
`ifdef TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_rw_app.md
Name: ddr_rw_app

Overview:
Parametrised DDR user-interface engine that issues BL back-to-back bursts to the memory controller app port, in write or read mode.
- Command path and write-data path are decoupled: app_rdy and app_wdf_rdy are handshaked independently.
- Read returns are forwarded to the user.
- The number of in-flight read commands is bounded.
- Sits between user DMA/test logic and the controller app interface, replacing the write-only engine.

Parameters:
ADDR_W, 28, app address width
DATA_W, 128, app data width (multiple of 8)
BURST_L, 8, address increment per burst command
BL_W, 8, width of bl and of the internal burst counters
MAX_OUTST, 16, max read commands issued but not yet returned (1..2^BL_W-1)
TIMEOUT_CYC, 1024, watchdog limit in cycles (TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  start pulse; sampled only in IDLE
wr_rd  in  1  1=write, 0=read; sampled with en
bl  in  BL_W  burst count; 0 treated as 1
addr  in  ADDR_W  start address; sampled with en
dat_i  in  DATA_W  write data; show-ahead, consumed when dat_req=1
dat_req  out  1  write beat consumed this cycle
rd_dat  out  DATA_W  read data to user
rd_vld  out  1  rd_dat valid
done  out  1  one-cycle completion pulse
busy  out  1  transaction in progress
err  out  1  one-cycle abort pulse (tied 0 without TIMEOUT_EN)
app_cmd  out  3  3'b000 write, 3'b001 read
app_addr  out  ADDR_W  command address
app_en  out  1  command valid
app_rdy  in  1  command accepted when app_en&app_rdy
app_wdf_data  out  DATA_W  = dat_i
app_wdf_mask  out  DATA_W/8  constant 0
app_wdf_wren  out  1  write data valid
app_wdf_end  out  1  = app_wdf_wren (one beat per burst)
app_wdf_rdy  in  1  data accepted when wren&wdf_rdy
app_rd_data  in  DATA_W  controller read data
app_rd_data_valid  in  1  read beat valid

Behaviour:
Clock, reset and state:
- Single clock.
- Reset is synchronous and active-high: rst sampled at posedge clk.
- Reset values: state=IDLE, all counters 0, done=0, busy=0, err=0, rd_vld=0, rd_dat=0, app_cmd=0.
- States: IDLE, WR, RD. One-hot encoding.

Start:
- IDLE & en: latch bl_r (bl==0 -> 1), addr_r=addr, app_cmd from wr_rd.
- Next state WR if wr_rd=1, else RD.
- en outside IDLE is ignored.
- busy=1 from the cycle after acceptance through the done cycle inclusive; busy=0 in the cycle after done.

Counters:
- cmd_cnt: increments on app_en&app_rdy; app_addr = addr_r + cmd_cnt*BURST_L, wrapping modulo 2^ADDR_W.
- WR: app_en = (cmd_cnt<bl_r); app_wdf_wren = (dat_cnt<bl_r); dat_cnt increments on wren&wdf_rdy; dat_req = wren&wdf_rdy.
- Data may lead or lag commands by any amount.
- WR -> IDLE in the cycle both counts reach bl_r, including when the final cmd and final data handshake land in the same cycle.
- RD: app_en = (cmd_cnt<bl_r) & ((cmd_cnt-ret_cnt)<MAX_OUTST); ret_cnt increments on app_rd_data_valid.
- RD -> IDLE when ret_cnt reaches bl_r.

Read return path:
- rd_dat/rd_vld registered: 1-cycle latency from app_rd_data/app_rd_data_valid.
- app_rd_data_valid in IDLE or WR is dropped: rd_vld=0.

Completion:
- done pulses for one cycle, registered, one cycle after the final counting event.
- In RD, done coincides with rd_vld of the last beat.

Misc:
- app_wdf_mask all zeros.
- rst asserted mid-transaction: return to IDLE next edge, no done, outputs deasserted. Any controller-side cleanup is outside this block.
- Arithmetic: counters are BL_W bits; cmd_cnt-ret_cnt is BL_W-bit unsigned, never negative by construction.

Optional Feature:
TIMEOUT_EN
- Defined: a watchdog counter clears on any handshake or read return, otherwise increments while state!=IDLE.
- At TIMEOUT_CYC the block returns to IDLE, pulses err for one cycle and does not pulse done.
- The watchdog is held 0 in IDLE.
- Undefined: no watchdog logic; err tied 0.

Test Plan:
1. Write, bl=4, addr=0x100, app_rdy=app_wdf_rdy=1 -> app_en/wren high 4 cycles; addrs 0x100,0x108,0x110,0x118; 4 dat_req; done one cycle later; busy falls next cycle.
2. Write, bl=3, app_rdy low the first 5 cycles, wdf_rdy=1 -> 3 data beats first, then 3 commands; done only after the 3rd command.
3. Read, bl=20, MAX_OUTST=4, returns delayed 10 cycles -> never more than 4 outstanding; 20 rd_vld beats with data intact; done on the 20th rd_vld.
4. bl=0 write, then addr=2^28-8 with bl=2 -> the bl=0 write performs exactly 1 burst; the second write's addresses are 0xFFFFFF8 then 0x0000000.
5. rst high mid-read after 2 of 8 returns -> IDLE next cycle, busy=0, no done; new write accepted afterwards.
6. TIMEOUT_EN, TIMEOUT_CYC=16, app_rdy stuck 0 -> err pulse at cycle 16 after start, busy=0, no done.
